uart_rx_block_packer: RTL and testbench

- Downstream consumer of the UART receiver's byte interface (rdy/data/rdy_clr).
- Captures each received byte, clears the receiver's ready flag, and packs BLOCK_BYTES bytes MSB-first into one wide block for the encryption core.
- Double-buffered: an assembly shift register plus an output holding register, so reception continues while the core drains the previous block.
- Drops bytes on overrun and flags it sticky.

---
 rtl/uart_rx_block_packer_if.sv | 27 ++
 rtl/uart_rx_block_packer.sv | 105 ++++++++++
 tb/tb_uart_rx_block_packer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_block_packer_if.sv
// uart_rx_block_packer_if: receiver byte handshake and packed block output bundle.
// master is the packer side, slave is the receiver/core side.
interface uart_rx_block_packer_if #(
    parameter int BLOCK_BYTES = 16
);
    logic                     rx_rdy;
    logic [7:0]               rx_data;
    logic                     rx_rdy_clr;
    logic                     flush;
    logic [8*BLOCK_BYTES-1:0] block_data;
    logic                     block_valid;
    logic                     block_ready;
    logic [5:0]               byte_count;
    logic                     overrun;
    logic                     overrun_clr;
    logic                     timeout;

    modport master (
        input  rx_rdy, rx_data, flush, block_ready, overrun_clr,
        output rx_rdy_clr, block_data, block_valid, byte_count, overrun, timeout
    );

    modport slave (
        output rx_rdy, rx_data, flush, block_ready, overrun_clr,
        input  rx_rdy_clr, block_data, block_valid, byte_count, overrun, timeout
    );
endinterface

// File: rtl/uart_rx_block_packer.sv
// uart_rx_block_packer: packs UART receiver bytes MSB-first into double-buffered wide blocks.
// Define RX_TIMEOUT_EN to build the idle timeout that discards partial blocks.
module uart_rx_block_packer #(
    parameter int BLOCK_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input logic                    clk_50m,
    input logic                    rst,
    uart_rx_block_packer_if.master bus
);
    localparam int         W    = 8 * BLOCK_BYTES;
    localparam logic [5:0] LAST = 6'(BLOCK_BYTES - 1);
    localparam logic [5:0] FULL = 6'(BLOCK_BYTES);

    if (BLOCK_BYTES < 2 || BLOCK_BYTES > 32 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 8388608) begin : g_bad_param
        $error("uart_rx_block_packer: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, FILLING, HELD} asm_state_t;

    asm_state_t   asm_state, n_state;
    logic [W-1:0] asm_reg, n_asm, n_data;
    logic [5:0]   n_cnt;
    logic         n_valid, capture, slot_free, held, ovr_set, fire;

    // rx_rdy is still high during the acknowledge cycle, so it must not count twice
    assign capture   = bus.rx_rdy & ~bus.rx_rdy_clr;
    assign slot_free = ~bus.block_valid | bus.block_ready;
    assign held      = asm_state == HELD && !bus.flush;

`ifdef RX_TIMEOUT_EN
    localparam logic [22:0] TMR_MAX = 23'(TIMEOUT_CYCLES - 1);
    logic [22:0] tmr;
    assign fire = asm_state == FILLING && !bus.flush && !capture && tmr == TMR_MAX;
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            tmr         <= '0;
            bus.timeout <= 1'b0;
        end else begin
            tmr         <= (capture || bus.flush || asm_state != FILLING || fire) ? '0 : tmr + 23'd1;
            bus.timeout <= fire;
        end
    end
`else
    assign fire        = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // flush is applied first so a same-cycle capture starts a fresh block
    always_comb begin
        n_asm   = bus.flush ? '0 : asm_reg;
        n_cnt   = bus.flush ? '0 : bus.byte_count;
        n_state = bus.flush ? IDLE : asm_state;
        n_data  = bus.block_data;
        n_valid = bus.block_valid & ~bus.block_ready;
        ovr_set = 1'b0;
        if (fire) begin
            n_asm   = '0;
            n_cnt   = '0;
            n_state = IDLE;
        end
        if (held && slot_free) begin
            n_data  = n_asm;
            n_valid = 1'b1;
            n_asm   = '0;
            n_cnt   = '0;
            n_state = IDLE;
        end
        if (capture) begin
            if (held && !slot_free) begin
                ovr_set = 1'b1;
            end else if (n_cnt == LAST && slot_free) begin
                n_data  = {n_asm[W-9:0], bus.rx_data};
                n_valid = 1'b1;
                n_asm   = '0;
                n_cnt   = '0;
                n_state = IDLE;
            end else begin
                n_asm   = {n_asm[W-9:0], bus.rx_data};
                n_cnt   = n_cnt + 6'd1;
                n_state = (n_cnt == FULL) ? HELD : FILLING;
            end
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            asm_state       <= IDLE;
            asm_reg         <= '0;
            bus.byte_count  <= '0;
            bus.block_data  <= '0;
            bus.block_valid <= 1'b0;
            bus.rx_rdy_clr  <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            asm_state       <= n_state;
            asm_reg         <= n_asm;
            bus.byte_count  <= n_cnt;
            bus.block_data  <= n_data;
            bus.block_valid <= n_valid;
            bus.rx_rdy_clr  <= capture;
            bus.overrun     <= ovr_set | (bus.overrun & ~bus.overrun_clr);
        end
    end
endmodule

// File: tb/tb_uart_rx_block_packer.sv
// tb_uart_rx_block_packer: table-driven block vectors plus hand sequences, blocks checked via scoreboard queue.
module tb_uart_rx_block_packer;
    logic clk_50m = 1'b0;
    logic rst     = 1'b1;

    uart_rx_block_packer_if #(.BLOCK_BYTES(16)) bif ();

    uart_rx_block_packer #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(100)) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (bif)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        logic [7:0]   base;
        logic [7:0]   step;
        int           pre;
        logic [127:0] exp;
    } vec_t;

    int           n_tests  = 0;
    int           n_fail   = 0;
    int           to_count = 0;
    logic [127:0] q[$];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk_50m);
            if (!rst && bif.timeout) to_count++;
            if (!rst && bif.block_valid && bif.block_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_block: got %0h, expected none", bif.block_data);
                end else begin
                    check("block_data", bif.block_data, q.pop_front());
                end
            end
        end
    endtask

    // receiver model: raises rdy, holds it through the acknowledge cycle, then drops it
    task automatic send_byte(input logic [7:0] b, output logic v);
        int n;
        n = 0;
        bif.rx_rdy  = 1'b1;
        bif.rx_data = b;
        do begin
            @(posedge clk_50m);
            #1;
            bif.flush = 1'b0;
            n++;
        end while (!bif.rx_rdy_clr && n < 8);
        check("ack_latency", 128'(n), 128'd1);
        v = bif.block_valid;
        @(posedge clk_50m);
        #1;
        check("ack_pulse_width", 128'(bif.rx_rdy_clr), 128'd0);
        bif.rx_rdy = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk_50m);
            #1;
            k++;
        end
        check("scoreboard_drain", 128'(q.size()), 128'd0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_rdy_clr"}, 128'(bif.rx_rdy_clr), 128'd0);
        check({tag, "_valid"}, 128'(bif.block_valid), 128'd0);
        check({tag, "_data"}, bif.block_data, 128'd0);
        check({tag, "_count"}, 128'(bif.byte_count), 128'd0);
        check({tag, "_overrun"}, 128'(bif.overrun), 128'd0);
        check({tag, "_timeout"}, 128'(bif.timeout), 128'd0);
    endtask

    task automatic flush_pulse();
        bif.flush = 1'b1;
        @(posedge clk_50m);
        #1;
        bif.flush = 1'b0;
        check("flush_count", 128'(bif.byte_count), 128'd0);
    endtask

    initial begin
        vec_t vecs[4];
        logic v;
        int   k;
        vecs[0] = '{8'h00, 8'h01, 0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{8'hA0, 8'h01, 5,  128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf};
        vecs[2] = '{8'hFF, 8'hFF, 0,  128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0};
        vecs[3] = '{8'h11, 8'h11, 15, 128'h112233445566778899aabbccddeeff10};
        bif.rx_rdy      = 1'b0;
        bif.rx_data     = 8'h00;
        bif.flush       = 1'b0;
        bif.block_ready = 1'b1;
        bif.overrun_clr = 1'b0;
        fork monitor(); join_none
        repeat (3) @(posedge clk_50m);
        #1;
        check_zero("reset");
        rst = 1'b0;

        foreach (vecs[t]) begin
            for (int i = 0; i < vecs[t].pre; i++) send_byte(8'h55 + 8'(i), v);
            check("pre_count", 128'(bif.byte_count), 128'(vecs[t].pre));
            if (vecs[t].pre != 0) flush_pulse();
            q.push_back(vecs[t].exp);
            for (int i = 0; i < 16; i++) begin
                send_byte(vecs[t].base + vecs[t].step * 8'(i), v);
                check("valid_after_capture", 128'(v), 128'(i == 15));
                check("byte_count", 128'(bif.byte_count), (i == 15) ? 128'd0 : 128'(i + 1));
            end
            drain();
        end

        // capture coinciding with flush becomes byte 1 of the new block
        for (int i = 0; i < 3; i++) send_byte(8'h70 + 8'(i), v);
        bif.flush = 1'b1;
        send_byte(8'h80, v);
        check("flush_capture_count", 128'(bif.byte_count), 128'd1);
        q.push_back(128'h808182838485868788898a8b8c8d8e8f);
        for (int i = 1; i < 16; i++) send_byte(8'h80 + 8'(i), v);
        drain();

        // two blocks with the core stalled, then an overrun byte
        bif.block_ready = 1'b0;
        q.push_back(128'h000102030405060708090a0b0c0d0e0f);
        q.push_back(128'h101112131415161718191a1b1c1d1e1f);
        for (int i = 0; i < 32; i++) send_byte(8'(i), v);
        check("held_count", 128'(bif.byte_count), 128'd16);
        check("held_valid", 128'(bif.block_valid), 128'd1);
        check("held_data_stable", bif.block_data, 128'h000102030405060708090a0b0c0d0e0f);
        send_byte(8'h20, v);
        check("overrun_set", 128'(bif.overrun), 128'd1);
        check("overrun_count", 128'(bif.byte_count), 128'd16);
        check("overrun_data_stable", bif.block_data, 128'h000102030405060708090a0b0c0d0e0f);
        bif.block_ready = 1'b1;
        @(posedge clk_50m);
        #1;
        check("swap_valid", 128'(bif.block_valid), 128'd1);
        check("swap_data", bif.block_data, 128'h101112131415161718191a1b1c1d1e1f);
        check("swap_count", 128'(bif.byte_count), 128'd0);
        @(posedge clk_50m);
        #1;
        check("drained_valid", 128'(bif.block_valid), 128'd0);
        check("overrun_sticky", 128'(bif.overrun), 128'd1);
        bif.overrun_clr = 1'b1;
        @(posedge clk_50m);
        #1;
        bif.overrun_clr = 1'b0;
        check("overrun_clr", 128'(bif.overrun), 128'd0);
        drain();

        // idle partial block
        to_count = 0;
        for (int i = 0; i < 3; i++) send_byte(8'h61 + 8'(i), v);
`ifdef RX_TIMEOUT_EN
        k = 1;
        while (!bif.timeout && k < 300) begin
            @(posedge clk_50m);
            #1;
            k++;
        end
        check("timeout_delay", 128'(k), 128'd100);
        check("timeout_count", 128'(bif.byte_count), 128'd0);
        @(posedge clk_50m);
        #1;
        check("timeout_pulse_width", 128'(bif.timeout), 128'd0);
        check("timeout_pulses", 128'(to_count), 128'd1);
        to_count = 0;
        for (int i = 0; i < 3; i++) send_byte(8'h61 + 8'(i), v);
        repeat (98) @(posedge clk_50m);
        #1;
        send_byte(8'h64, v);
        check("late_byte_count", 128'(bif.byte_count), 128'd4);
        repeat (20) @(posedge clk_50m);
        #1;
        check("late_byte_no_timeout", 128'(to_count), 128'd0);
        flush_pulse();
`else
        k = 0;
        repeat (200) @(posedge clk_50m);
        #1;
        check("no_timeout", 128'(to_count), 128'(k));
        check("partial_kept", 128'(bif.byte_count), 128'd3);
        flush_pulse();
`endif

        // asynchronous reset with a held block and a partial block
        bif.block_ready = 1'b0;
        for (int i = 0; i < 23; i++) send_byte(8'h40 + 8'(i), v);
        check("pre_reset_count", 128'(bif.byte_count), 128'd7);
        check("pre_reset_valid", 128'(bif.block_valid), 128'd1);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk_50m);
        #1;
        rst = 1'b0;
        bif.block_ready = 1'b1;
        q.push_back(128'h505152535455565758595a5b5c5d5e5f);
        for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i), v);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
